// File: rtl/zbus_seq_checker_if.sv
// zbus handshake bundle: valid/payload from the source, registered acknowledge
// from the sink. The master modport is the source side, slave is the sink side.
interface zbus_seq_checker_if #(
   parameter int BW = 8
);
   logic          z_vld;
   logic [BW-1:0] z_bus;
   logic          z_ack;

   modport master (output z_vld, output z_bus, input z_ack);
   modport slave  (input z_vld, input z_bus, output z_ack);
endinterface

// File: rtl/zbus_seq_checker.sv
// zbus sequence checker: terminates a zbus stream, compares each accepted word
// against an incrementing expected value under a bit mask, counts transfers and
// mismatches, and captures the first mismatch.
// Optional build macro ZBUS_SEQ_CHECKER_LFSR_EN adds LFSR-driven backpressure on
// z_ack; without it z_ack is simply en (and not clr) registered.
module zbus_seq_checker #(
   parameter int          BW   = 8,
   parameter int          CW   = 16,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic                 z_clk,
   input  logic                 z_rst,
   input  logic                 en,
   input  logic                 clr,
   input  logic [BW-1:0]        msk,
   zbus_seq_checker_if.slave    zb,
   output logic [BW-1:0]        exp,
   output logic [CW-1:0]        trn_cnt,
   output logic [CW-1:0]        err_cnt,
   output logic                 err,
   output logic [BW-1:0]        err_dat,
   output logic [BW-1:0]        err_exp
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   // An all-zero seed would lock the backpressure LFSR; refuse it at elaboration.
   if (SEED == 16'h0000) begin : g_seed_chk
      $error("zbus_seq_checker: SEED must be nonzero");
   end

   logic          r_ack;
   logic [BW-1:0] r_exp;
   logic [CW-1:0] r_trn_cnt;
   logic [CW-1:0] r_err_cnt;
   logic          r_err;
   logic [BW-1:0] r_err_dat;
   logic [BW-1:0] r_err_exp;
   logic          w_ack_pat;
   logic          w_trn;
   logic          w_mism;

`ifdef ZBUS_SEQ_CHECKER_LFSR_EN
   logic [15:0] r_lfsr;
   logic        w_fb;

   // Taps for x^16+x^14+x^13+x^11+1 in a left-shifting Fibonacci register.
   assign w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_ack_pat = |r_lfsr[1:0];

   // Backpressure pattern generator; frozen while the checker is disabled.
   always_ff @(posedge z_clk or negedge z_rst) begin
      if (!z_rst) begin
         r_lfsr <= SEED;
      end else if (clr) begin
         r_lfsr <= SEED;
      end else if (en) begin
         r_lfsr <= {r_lfsr[14:0], w_fb};
      end
   end
`else
   assign w_ack_pat = 1'b1;
`endif

   // A handshake completes only on the registered ack, so z_vld never reaches z_ack.
   assign w_trn  = zb.z_vld & r_ack;
   assign w_mism = |((zb.z_bus ^ r_exp) & msk);

   // Acknowledge register: reacts to en/clr one cycle later.
   always_ff @(posedge z_clk or negedge z_rst) begin
      if (!z_rst) begin
         r_ack <= 1'b0;
      end else begin
         r_ack <= en & ~clr & w_ack_pat;
      end
   end

   // Sequence check, saturating counters and first-mismatch capture. A transfer
   // coinciding with clr is consumed by the handshake but deliberately ignored.
   always_ff @(posedge z_clk or negedge z_rst) begin
      if (!z_rst) begin
         r_exp     <= '0;
         r_trn_cnt <= '0;
         r_err_cnt <= '0;
         r_err     <= 1'b0;
         r_err_dat <= '0;
         r_err_exp <= '0;
      end else if (clr) begin
         r_exp     <= '0;
         r_trn_cnt <= '0;
         r_err_cnt <= '0;
         r_err     <= 1'b0;
         r_err_dat <= '0;
         r_err_exp <= '0;
      end else if (w_trn) begin
         r_exp <= r_exp + 1'b1;
         if (r_trn_cnt != CNT_MAX) begin
            r_trn_cnt <= r_trn_cnt + 1'b1;
         end
         if (w_mism) begin
            if (r_err_cnt != CNT_MAX) begin
               r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (!r_err) begin
               r_err     <= 1'b1;
               r_err_dat <= zb.z_bus;
               r_err_exp <= r_exp;
            end
         end
      end
   end

   assign zb.z_ack = r_ack;
   assign exp      = r_exp;
   assign trn_cnt  = r_trn_cnt;
   assign err_cnt  = r_err_cnt;
   assign err      = r_err;
   assign err_dat  = r_err_dat;
   assign err_exp  = r_err_exp;

endmodule

// File: tb/tb_zbus_seq_checker.sv
// Bench for zbus_seq_checker: a driver issues directed zbus words and pushes the
// expected post-transfer status into a queue; a monitor pops and compares each
// time a handshake completes. An independent ack model checks z_ack every cycle.
module tb_zbus_seq_checker;

   localparam int          BW   = 8;
   localparam int          CW   = 16;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          z_clk = 1'b0;
   logic          z_rst;
   logic          en;
   logic          clr;
   logic [BW-1:0] msk;
   logic [BW-1:0] exp_o;
   logic [CW-1:0] trn_cnt;
   logic [CW-1:0] err_cnt;
   logic          err;
   logic [BW-1:0] err_dat;
   logic [BW-1:0] err_exp;

   zbus_seq_checker_if #(.BW(BW)) zb ();

   zbus_seq_checker #(.BW(BW), .CW(CW), .SEED(SEED)) dut (
      .z_clk   (z_clk),
      .z_rst   (z_rst),
      .en      (en),
      .clr     (clr),
      .msk     (msk),
      .zb      (zb),
      .exp     (exp_o),
      .trn_cnt (trn_cnt),
      .err_cnt (err_cnt),
      .err     (err),
      .err_dat (err_dat),
      .err_exp (err_exp)
   );

   always #5 z_clk = ~z_clk;

   typedef struct packed {
      logic [BW-1:0] e_exp;
      logic [CW-1:0] e_trn;
      logic [CW-1:0] e_errc;
      logic          e_err;
      logic [BW-1:0] e_dat;
      logic [BW-1:0] e_eexp;
   } rec_t;

   rec_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   stalls   = 0;

   logic [BW-1:0] m_exp;
   logic [CW-1:0] m_trn;
   logic [CW-1:0] m_errc;
   logic          m_err;
   logic [BW-1:0] m_dat;
   logic [BW-1:0] m_eexp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic void model_clr();
      m_exp  = '0;
      m_trn  = '0;
      m_errc = '0;
      m_err  = 1'b0;
      m_dat  = '0;
      m_eexp = '0;
   endfunction

   function automatic void model_trn(input logic [BW-1:0] v);
      logic mism;
      mism = |((v ^ m_exp) & msk);
      if (mism) begin
         if (m_errc != '1) m_errc = m_errc + 1'b1;
         if (!m_err) begin
            m_err  = 1'b1;
            m_dat  = v;
            m_eexp = m_exp;
         end
      end
      if (m_trn != '1) m_trn = m_trn + 1'b1;
      m_exp = m_exp + 1'b1;
   endfunction

   function automatic rec_t snap();
      rec_t r;
      r.e_exp  = m_exp;
      r.e_trn  = m_trn;
      r.e_errc = m_errc;
      r.e_err  = m_err;
      r.e_dat  = m_dat;
      r.e_eexp = m_eexp;
      return r;
   endfunction

   // Present one word and hold it until the handshake completes (bounded).
   task automatic send(input logic [BW-1:0] v);
      int   waits;
      logic ok;
      @(negedge z_clk);
      zb.z_vld = 1'b1;
      zb.z_bus = v;
      model_trn(v);
      sb_q.push_back(snap());
      waits = 0;
      ok    = zb.z_ack;
      while (!ok && waits < 50) begin
         @(negedge z_clk);
         ok = zb.z_ack;
         waits++;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=no_ack required=ack value=%0h", v);
         void'(sb_q.pop_back());
      end else begin
         @(posedge z_clk);
         stalls += waits;
      end
   endtask

   task automatic idle(input int n);
      @(negedge z_clk);
      zb.z_vld = 1'b0;
      zb.z_bus = BW'($urandom);
      repeat (n) @(negedge z_clk);
   endtask

   task automatic do_clr();
      @(negedge z_clk);
      zb.z_vld = 1'b0;
      clr      = 1'b1;
      @(negedge z_clk);
      clr = 1'b0;
      model_clr();
   endtask

   // Handshake detector, sampled mid-cycle once the driver has settled.
   logic mon_trn = 1'b0;
   always @(negedge z_clk) begin
      #2;
      mon_trn = zb.z_vld & zb.z_ack & z_rst;
   end

   // Scoreboard monitor: one expected status record per completed handshake.
   always @(posedge z_clk) begin
      rec_t exp_r;
      rec_t got;
      #1;
      if (mon_trn) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_trn actual=trn required=none");
         end else begin
            exp_r = sb_q.pop_front();
            got   = {exp_o, trn_cnt, err_cnt, err, err_dat, err_exp};
            if (got !== exp_r) begin
               failures++;
               $display("FAIL sb_status actual exp=%0h trn=%0d errc=%0d err=%0b dat=%0h eexp=%0h required exp=%0h trn=%0d errc=%0d err=%0b dat=%0h eexp=%0h",
                        got.e_exp, got.e_trn, got.e_errc, got.e_err, got.e_dat, got.e_eexp,
                        exp_r.e_exp, exp_r.e_trn, exp_r.e_errc, exp_r.e_err, exp_r.e_dat, exp_r.e_eexp);
            end
         end
      end
   end

   // Reference acknowledge: en & ~clr & pattern, registered, async reset.
   logic m_ack;
   logic m_pat;
`ifdef ZBUS_SEQ_CHECKER_LFSR_EN
   logic [15:0] m_lfsr;
   assign m_pat = |m_lfsr[1:0];
   always @(posedge z_clk or negedge z_rst) begin
      if (!z_rst) begin
         m_lfsr <= SEED;
      end else if (clr) begin
         m_lfsr <= SEED;
      end else if (en) begin
         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
   end
`else
   assign m_pat = 1'b1;
`endif

   always @(posedge z_clk or negedge z_rst) begin
      if (!z_rst) m_ack <= 1'b0;
      else        m_ack <= en & ~clr & m_pat;
   end

   always @(posedge z_clk) begin
      #1;
      if (z_rst) begin
         checks++;
         if (zb.z_ack !== m_ack) begin
            failures++;
            $display("FAIL ack_model actual=%0b required=%0b t=%0t", zb.z_ack, m_ack, $time);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      z_rst    = 1'b0;
      en       = 1'b0;
      clr      = 1'b0;
      msk      = 8'hFF;
      zb.z_vld = 1'b0;
      zb.z_bus = '0;
      model_clr();
      #1;
      chk("rst_ack", 32'(zb.z_ack), 32'd0);
      chk("rst_exp", 32'(exp_o), 32'd0);
      chk("rst_trn", 32'(trn_cnt), 32'd0);
      chk("rst_errc", 32'(err_cnt), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_capture", {16'd0, err_dat, err_exp}, 32'd0);
      repeat (2) @(negedge z_clk);
      z_rst = 1'b1;
      en    = 1'b1;

      // 1: clean back-to-back stream 0..18
      send(8'd0);
      stalls = 0;
      for (int i = 1; i < 19; i++) send(BW'(i));
      idle(2);
      chk("t1_trn", 32'(trn_cnt), 32'd19);
      chk("t1_errc", 32'(err_cnt), 32'd0);
      chk("t1_err", 32'(err), 32'd0);
      chk("t1_exp", 32'(exp_o), 32'd19);
`ifndef ZBUS_SEQ_CHECKER_LFSR_EN
      chk("t1_ack_held", 32'(stalls), 32'd0);
`endif

      // 2: one bad word in the sequence
      do_clr();
      send(8'd0); send(8'd1); send(8'd2); send(8'd7); send(8'd4);
      idle(2);
      chk("t2_err", 32'(err), 32'd1);
      chk("t2_err_dat", 32'(err_dat), 32'h07);
      chk("t2_err_exp", 32'(err_exp), 32'h03);
      chk("t2_errc", 32'(err_cnt), 32'd1);
      chk("t2_exp", 32'(exp_o), 32'd5);

      // 3: masked compare, then fully masked
      do_clr();
      msk = 8'h0F;
      send(8'hF0); send(8'h01); send(8'h12);
      idle(2);
      chk("t3_errc", 32'(err_cnt), 32'd0);
      chk("t3_err", 32'(err), 32'd0);
      chk("t3_trn", 32'(trn_cnt), 32'd3);
      msk = 8'h00;
      send(8'hAA);
      idle(2);
      chk("t3_nomask_trn", 32'(trn_cnt), 32'd4);
      chk("t3_nomask_err", 32'(err), 32'd0);
      msk = 8'hFF;

      // 4: expected value wraps cleanly
      do_clr();
      for (int i = 0; i < 256; i++) send(BW'(i));
      for (int i = 0; i < 4; i++) send(BW'(i));
      idle(2);
      chk("t4_trn", 32'(trn_cnt), 32'd260);
      chk("t4_errc", 32'(err_cnt), 32'd0);
      chk("t4_exp", 32'(exp_o), 32'd4);

      // 5: clr with a live handshake, then clr during a captured error
      do_clr();
      for (int i = 0; i < 5; i++) send(BW'(i));
      begin
         logic ok;
         @(negedge z_clk);
         zb.z_vld = 1'b1;
         zb.z_bus = 8'd5;
         clr      = 1'b1;
         ok       = zb.z_ack;
         model_clr();
         if (ok) sb_q.push_back(snap());
         @(negedge z_clk);
         clr      = 1'b0;
         zb.z_vld = 1'b0;
         chk("t5_ack_after_clr", 32'(zb.z_ack), 32'd0);
         chk("t5_trn_after_clr", 32'(trn_cnt), 32'd0);
      end
      send(8'd0); send(8'd1); send(8'd2);
      idle(2);
      chk("t5_trn", 32'(trn_cnt), 32'd3);
      chk("t5_exp", 32'(exp_o), 32'd3);
      chk("t5_err", 32'(err), 32'd0);
      send(8'd9);
      idle(2);
      chk("t5_err_set", 32'(err), 32'd1);
      do_clr();
      chk("t5_err_clr", 32'(err), 32'd0);
      chk("t5_capture_clr", {16'd0, err_dat, err_exp}, 32'd0);
      chk("t5_errc_clr", 32'(err_cnt), 32'd0);

      // 6: asynchronous reset mid-stream
      send(8'd0); send(8'd5);
      @(negedge z_clk);
      chk("t6_err_pre", 32'(err), 32'd1);
      zb.z_vld = 1'b1;
      zb.z_bus = 8'd2;
      z_rst    = 1'b0;
      #1;
      chk("t6_rst_ack", 32'(zb.z_ack), 32'd0);
      chk("t6_rst_trn", 32'(trn_cnt), 32'd0);
      chk("t6_rst_err", 32'(err), 32'd0);
      model_clr();
      repeat (2) @(negedge z_clk);
      zb.z_vld = 1'b0;
      z_rst    = 1'b1;
      for (int i = 0; i < 4; i++) send(BW'(i));
      idle(2);
      chk("t6_trn", 32'(trn_cnt), 32'd4);
      chk("t6_err", 32'(err), 32'd0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
